// File: rtl/tlb_ctrl_if.sv
// rtl/tlb_ctrl_if.sv - requester, TLB and page-walk signal bundle for tlb_ctrl
interface tlb_ctrl_if #(
    parameter int SADDR = 64,
    parameter int SPCID = 12,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*SADDR-1:0] req_va;
    logic [NREQ*SPCID-1:0] req_pcid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [SADDR-1:0]      rsp_ta;
    logic                  rsp_fault;
    logic                  tlb_lk_valid;
    logic [SADDR-1:0]      tlb_va;
    logic [SPCID-1:0]      tlb_pcid;
    logic                  tlb_hit;
    logic                  tlb_miss;
    logic [SADDR-1:0]      tlb_ta;
    logic                  tlb_fill;
    logic [SADDR-1:0]      tlb_fill_pa;
    logic                  walk_req;
    logic                  walk_done;
    logic [SADDR-1:0]      walk_pa;
    logic                  walk_fault;

    modport master (
        input  req_valid, req_va, req_pcid, tlb_hit, tlb_miss, tlb_ta,
               walk_done, walk_pa, walk_fault,
        output req_ready, rsp_valid, rsp_ta, rsp_fault, tlb_lk_valid, tlb_va,
               tlb_pcid, tlb_fill, tlb_fill_pa, walk_req
    );

    modport slave (
        output req_valid, req_va, req_pcid, tlb_hit, tlb_miss, tlb_ta,
               walk_done, walk_pa, walk_fault,
        input  req_ready, rsp_valid, rsp_ta, rsp_fault, tlb_lk_valid, tlb_va,
               tlb_pcid, tlb_fill, tlb_fill_pa, walk_req
    );
endinterface

// File: rtl/tlb_ctrl.sv
// rtl/tlb_ctrl.sv - round-robin TLB lookup sequencer with page-walk fill path
module tlb_ctrl #(
    parameter int SADDR = 64,
    parameter int SPAGE = 12,
    parameter int SPCID = 12,
    parameter int NREQ  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    tlb_ctrl_if.master bus
);
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WALK, FILL, RESP} state_t;

    state_t            state_q, state_d;
    logic [RRW-1:0]    rr_q, rr_d;
    logic [RRW-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [SADDR-1:0]  rsp_ta_q, rsp_ta_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              tlb_lk_valid_q, tlb_lk_valid_d;
    logic [SADDR-1:0]  tlb_va_q, tlb_va_d;
    logic [SPCID-1:0]  tlb_pcid_q, tlb_pcid_d;
    logic              tlb_fill_q, tlb_fill_d;
    logic [SADDR-1:0]  tlb_fill_pa_q, tlb_fill_pa_d;
    logic              walk_req_q, walk_req_d;

    logic              found;
    logic [RRW-1:0]    win;
    logic              unused_walk_off;

    // Only the page field of the walked address matters; the offset comes from the VA.
    assign unused_walk_off = ^bus.walk_pa[SPAGE-1:0];

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = RRW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        gnt_d          = gnt_q;
        req_ready_d    = '0;
        rsp_valid_d    = '0;
        rsp_ta_d       = rsp_ta_q;
        rsp_fault_d    = rsp_fault_q;
        tlb_lk_valid_d = 1'b0;
        tlb_va_d       = tlb_va_q;
        tlb_pcid_d     = tlb_pcid_q;
        tlb_fill_d     = 1'b0;
        tlb_fill_pa_d  = tlb_fill_pa_q;
        walk_req_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_d[win] = 1'b1;
                    gnt_d            = win;
                    rr_d             = (win == RRW'(NREQ - 1)) ? '0 : win + RRW'(1);
                    tlb_va_d         = bus.req_va[win*SADDR +: SADDR];
                    tlb_pcid_d       = bus.req_pcid[win*SPCID +: SPCID];
                    tlb_lk_valid_d   = 1'b1;
                    state_d          = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.tlb_hit) begin
                    rsp_ta_d           = bus.tlb_ta;
                    rsp_fault_d        = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end else if (bus.tlb_miss) begin
                    walk_req_d = 1'b1;
                    state_d    = WALK;
                end else begin
                    tlb_lk_valid_d = 1'b1;
                end
            end
            WALK: begin
                if (bus.walk_done) begin
                    if (bus.walk_fault) begin
                        rsp_fault_d        = 1'b1;
                        rsp_ta_d           = '0;
                        rsp_valid_d[gnt_q] = 1'b1;
                        state_d            = RESP;
                    end else begin
                        tlb_fill_pa_d = {bus.walk_pa[SADDR-1:SPAGE], tlb_va_q[SPAGE-1:0]};
                        tlb_fill_d    = 1'b1;
                        state_d       = FILL;
                    end
                end else begin
                    walk_req_d = 1'b1;
                end
            end
            FILL: begin
                rsp_ta_d           = tlb_fill_pa_q;
                rsp_fault_d        = 1'b0;
                rsp_valid_d[gnt_q] = 1'b1;
                state_d            = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_q           <= '0;
            gnt_q          <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_ta_q       <= '0;
            rsp_fault_q    <= 1'b0;
            tlb_lk_valid_q <= 1'b0;
            tlb_va_q       <= '0;
            tlb_pcid_q     <= '0;
            tlb_fill_q     <= 1'b0;
            tlb_fill_pa_q  <= '0;
            walk_req_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            gnt_q          <= gnt_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_ta_q       <= rsp_ta_d;
            rsp_fault_q    <= rsp_fault_d;
            tlb_lk_valid_q <= tlb_lk_valid_d;
            tlb_va_q       <= tlb_va_d;
            tlb_pcid_q     <= tlb_pcid_d;
            tlb_fill_q     <= tlb_fill_d;
            tlb_fill_pa_q  <= tlb_fill_pa_d;
            walk_req_q     <= walk_req_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_ta       = rsp_ta_q;
    assign bus.rsp_fault    = rsp_fault_q;
    assign bus.tlb_lk_valid = tlb_lk_valid_q;
    assign bus.tlb_va       = tlb_va_q;
    assign bus.tlb_pcid     = tlb_pcid_q;
    assign bus.tlb_fill     = tlb_fill_q;
    assign bus.tlb_fill_pa  = tlb_fill_pa_q;
    assign bus.walk_req     = walk_req_q;
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb/tb_tlb_ctrl.sv - directed self-checking bench for tlb_ctrl
module tb_tlb_ctrl;
    localparam int SADDR = 64;
    localparam int SPAGE = 12;
    localparam int SPCID = 12;
    localparam int NREQ  = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    tlb_ctrl_if #(.SADDR(SADDR), .SPCID(SPCID), .NREQ(NREQ)) bus ();

    tlb_ctrl #(.SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder knobs: 0 = hit, 1 = miss, 2 = hit and miss together.
    int               tlb_mode;
    logic [SADDR-1:0] tlb_ta_val;
    int               walk_delay;
    logic [SADDR-1:0] walk_pa_val;
    logic             walk_fault_val;

    int               rsp_cnt;
    logic [NREQ-1:0]  rsp_v;
    logic [SADDR-1:0] rsp_ta_v;
    logic             rsp_fault_v;
    int               walk_cycles;
    int               fill_cnt;
    logic [SADDR-1:0] fill_pa_v;
    logic [SADDR-1:0] lk_va_v;
    logic [SPCID-1:0] lk_pcid_v;
    logic [NREQ-1:0]  gnt_log[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        walk_cycles = 0;
        fill_cnt    = 0;
        gnt_log.delete();
    endtask

    // TLB answers in the second cycle of tlb_lk_valid; walk_done after walk_delay cycles of walk_req.
    initial begin
        int lk_cnt;
        int wk_cnt;
        lk_cnt = 0;
        wk_cnt = 0;
        forever begin
            tick();
            bus.tlb_hit    = 1'b0;
            bus.tlb_miss   = 1'b0;
            bus.walk_done  = 1'b0;
            bus.walk_fault = 1'b0;
            if (bus.tlb_lk_valid) begin
                lk_cnt++;
                if (lk_cnt == 2) begin
                    bus.tlb_hit  = (tlb_mode != 1);
                    bus.tlb_miss = (tlb_mode != 0);
                    bus.tlb_ta   = tlb_ta_val;
                end
            end else begin
                lk_cnt = 0;
            end
            if (bus.walk_req) begin
                wk_cnt++;
                if (wk_cnt == walk_delay) begin
                    bus.walk_done  = 1'b1;
                    bus.walk_pa    = walk_pa_val;
                    bus.walk_fault = walk_fault_val;
                end
            end else begin
                wk_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.req_ready != '0) gnt_log.push_back(bus.req_ready);
        if (bus.tlb_lk_valid) begin
            lk_va_v   = bus.tlb_va;
            lk_pcid_v = bus.tlb_pcid;
        end
        if (bus.walk_req) walk_cycles++;
        if (bus.tlb_fill) begin
            fill_cnt++;
            fill_pa_v = bus.tlb_fill_pa;
        end
        if (bus.rsp_valid != '0) begin
            rsp_cnt++;
            rsp_v       = bus.rsp_valid;
            rsp_ta_v    = bus.rsp_ta;
            rsp_fault_v = bus.rsp_fault;
        end
    end

    task automatic do_req(input int r, input logic [SADDR-1:0] va, input logic [SPCID-1:0] pcid,
                          input bit wait_rsp);
        int n;
        int start;
        start = rsp_cnt;
        bus.req_va[r*SADDR +: SADDR]   = va;
        bus.req_pcid[r*SPCID +: SPCID] = pcid;
        bus.req_valid[r]               = 1'b1;
        n = 0;
        while (!bus.req_ready[r] && n < 50) begin
            tick();
            n++;
        end
        check_eq("grant_seen", bus.req_ready[r], 1);
        bus.req_valid[r] = 1'b0;
        if (wait_rsp) begin
            n = 0;
            while (rsp_cnt == start && n < 200) begin
                tick();
                n++;
            end
            check_eq("rsp_seen", 64'(rsp_cnt - start), 1);
        end
    endtask

    initial begin
        int n;
        n_checks       = 0;
        n_fail         = 0;
        rsp_cnt        = 0;
        tlb_mode       = 0;
        tlb_ta_val     = '0;
        walk_delay     = 5;
        walk_pa_val    = '0;
        walk_fault_val = 1'b0;
        bus.req_valid  = '0;
        bus.req_va     = '0;
        bus.req_pcid   = '0;
        bus.tlb_hit    = 1'b0;
        bus.tlb_miss   = 1'b0;
        bus.tlb_ta     = '0;
        bus.walk_done  = 1'b0;
        bus.walk_pa    = '0;
        bus.walk_fault = 1'b0;
        rst_n          = 1'b0;
        clr_mon();
        repeat (2) tick();
        check_eq("rst_req_ready", bus.req_ready, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_lk_valid", bus.tlb_lk_valid, 0);
        check_eq("rst_walk_req", bus.walk_req, 0);
        check_eq("rst_tlb_va", bus.tlb_va, 0);
        rst_n = 1'b1;
        tick();

        // Single hit
        clr_mon();
        tlb_mode   = 0;
        tlb_ta_val = 64'h0000_0000_0009_9ABC;
        do_req(0, 64'h0000_0000_0040_3ABC, 12'd5, 1'b1);
        check_eq("hit_grant_cnt", 64'(gnt_log.size()), 1);
        check_eq("hit_grant", gnt_log[0], 2'b01);
        check_eq("hit_lk_va", lk_va_v, 64'h0000_0000_0040_3ABC);
        check_eq("hit_lk_pcid", lk_pcid_v, 5);
        check_eq("hit_rsp_valid", rsp_v, 2'b01);
        check_eq("hit_rsp_ta", rsp_ta_v, 64'h0000_0000_0009_9ABC);
        check_eq("hit_rsp_fault", rsp_fault_v, 0);
        check_eq("hit_no_walk", 64'(walk_cycles), 0);
        check_eq("hit_no_fill", 64'(fill_cnt), 0);
        tick();
        check_eq("rsp_one_cycle", bus.rsp_valid, 0);

        // Miss, 5-cycle walk, fill
        clr_mon();
        tlb_mode    = 1;
        walk_delay  = 5;
        walk_pa_val = 64'h0000_0000_0077_7000;
        do_req(0, 64'h0000_0000_0012_3456, 12'd7, 1'b1);
        check_eq("miss_walk_cycles", 64'(walk_cycles), 5);
        check_eq("miss_fill_cnt", 64'(fill_cnt), 1);
        check_eq("miss_fill_pa", fill_pa_v, 64'h0000_0000_0077_7456);
        check_eq("miss_rsp_ta", rsp_ta_v, 64'h0000_0000_0077_7456);
        check_eq("miss_rsp_fault", rsp_fault_v, 0);
        check_eq("miss_rsp_valid", rsp_v, 2'b01);

        // Walk fault
        clr_mon();
        tlb_mode       = 1;
        walk_delay     = 3;
        walk_fault_val = 1'b1;
        do_req(0, 64'h0000_0000_00AB_C123, 12'd9, 1'b1);
        walk_fault_val = 1'b0;
        check_eq("flt_no_fill", 64'(fill_cnt), 0);
        check_eq("flt_rsp_fault", rsp_fault_v, 1);
        check_eq("flt_rsp_ta", rsp_ta_v, 0);
        check_eq("flt_rsp_valid", rsp_v, 2'b01);

        // Hit and miss together resolve as a hit
        clr_mon();
        tlb_mode   = 2;
        tlb_ta_val = 64'h0000_0000_0055_5DEF;
        do_req(0, 64'h0000_0000_0033_3DEF, 12'd1, 1'b1);
        check_eq("both_no_walk", 64'(walk_cycles), 0);
        check_eq("both_rsp_ta", rsp_ta_v, 64'h0000_0000_0055_5DEF);
        check_eq("both_rsp_fault", rsp_fault_v, 0);

        // Async reset while walking; rr pointer is 1 before the reset
        clr_mon();
        tlb_mode   = 1;
        walk_delay = 50;
        do_req(0, 64'h0000_0000_0044_4111, 12'd2, 1'b0);
        n = 0;
        while (!bus.walk_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("ar_walk_req", bus.walk_req, 1);
        tick();
        #2;
        n = rsp_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("ar_walk_req_0", bus.walk_req, 0);
        check_eq("ar_tlb_va_0", bus.tlb_va, 0);
        check_eq("ar_tlb_pcid_0", bus.tlb_pcid, 0);
        check_eq("ar_rsp_ta_0", bus.rsp_ta, 0);
        check_eq("ar_fill_pa_0", bus.tlb_fill_pa, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_eq("ar_no_rsp", 64'(rsp_cnt - n), 0);
        check_eq("ar_idle_ready", bus.req_ready, 0);

        // Round robin with both requesters held, all hits
        clr_mon();
        tlb_mode   = 0;
        tlb_ta_val = 64'h0000_0000_0066_6000;
        bus.req_va    = {64'h0000_0000_0011_1000, 64'h0000_0000_0022_2000};
        bus.req_valid = 2'b11;
        n = rsp_cnt;
        for (int i = 0; i < 200 && gnt_log.size() < 4; i++) tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 50 && rsp_cnt - n < 4; i++) tick();
        check_eq("rr_grant_cnt", 64'(gnt_log.size()), 4);
        check_eq("rr_rsp_cnt", 64'(rsp_cnt - n), 4);
        if (gnt_log.size() >= 4) begin
            check_eq("rr_g0", gnt_log[0], 2'b01);
            check_eq("rr_g1", gnt_log[1], 2'b10);
            check_eq("rr_g2", gnt_log[2], 2'b01);
            check_eq("rr_g3", gnt_log[3], 2'b10);
        end
        check_eq("rr_last_rsp", rsp_v, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
